// File: rtl/fatori_mon_pkg.sv
// rtl/fatori_mon_pkg.sv - shared types, register map and helpers for the fatori error monitor
//
// Purpose: register-index constants, first-error type and FSM state enums,
//          popcount and lowest-set-bit helpers used by the collector.
// Ports:   none (package).
package fatori_mon_pkg;

  localparam logic [2:0] REG_MIN_CNT    = 3'd0;
  localparam logic [2:0] REG_MAJ_CNT    = 3'd1;
  localparam logic [2:0] REG_SCRUB_CNT  = 3'd2;
  localparam logic [2:0] REG_MIN_STICKY = 3'd3;
  localparam logic [2:0] REG_MAJ_STICKY = 3'd4;
  localparam logic [2:0] REG_FE_INFO    = 3'd5;
  localparam logic [2:0] REG_FE_TS      = 3'd6;
  localparam logic [2:0] REG_ID         = 3'd7;

  localparam logic [15:0] ID_MAGIC = 16'hFA70;

  // Width of a per-cycle event popcount (up to 32 sources).
  localparam int unsigned POP_W = 6;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_MIN  = 2'b01,
    ERR_MAJ  = 2'b10
  } err_type_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CAPTURED = 1'b1
  } fe_state_e;

  function automatic logic [POP_W-1:0] popcount32(input logic [31:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // Scans downwards so the last hit, and therefore the result, is the lowest set bit.
  function automatic logic [4:0] lowest_idx32(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fatori_mon_sat_ctr.sv
// rtl/fatori_mon_sat_ctr.sv - saturating event counter with synchronous clear
//
// Purpose: adds a small increment every cycle, sticking at all-ones instead of
//          wrapping. A clear in the same cycle as an increment restarts the
//          count from the increment.
// Ports:   clk_i    clock
//          rst_ni   asynchronous active-low reset
//          clr_i    synchronous clear
//          inc_i    increment for this cycle
//          cnt_o    current count
module fatori_mon_sat_ctr #(
  parameter int unsigned W  = 16,
  parameter int unsigned IW = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [IW-1:0] inc_i,
  output logic [W-1:0]  cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   base;
  logic [W:0]   sum;

  always_comb begin
    base  = clr_i ? '0 : {1'b0, cnt_q};
    sum   = base + {{(W + 1 - IW){1'b0}}, inc_i};
    // Carry out of the W-bit range means the true total no longer fits.
    cnt_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fatori_mon_err_collector.sv
// rtl/fatori_mon_err_collector.sv - voter/scrub error collector for hardened wrappers
//
// Purpose: turns per-wrapper minority, no-majority and scrub flags into rising-edge
//          events, keeps saturating totals, sticky source masks, a free-running
//          cycle counter and a first-error record, and serves them over a
//          single-cycle-latency read port.
// Ports:   clk_i        clock
//          rst_ni       asynchronous active-low reset
//          min_err_i    per-wrapper minority-disagreement flags
//          maj_err_i    per-wrapper no-majority flags
//          scrub_i      per-wrapper scrub-occurred flags
//          clr_i        clear counters, sticky masks and first-error record
//          req_i        read request strobe
//          addr_i       read register index
//          rvalid_o     read data valid, one cycle after req_i
//          rdata_o      read data, zero when rvalid_o is low
//          maj_alert_o  any no-majority sticky bit set
//          irq_o        one-cycle pulse when the first error is recorded
module fatori_mon_err_collector
  import fatori_mon_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] min_err_i,
  input  logic [NUM_SRC-1:0] maj_err_i,
  input  logic [NUM_SRC-1:0] scrub_i,
  input  logic               clr_i,
  input  logic               req_i,
  input  logic [2:0]         addr_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               maj_alert_o,
  output logic               irq_o
);

  localparam logic [7:0] NUM_SRC_B = 8'(NUM_SRC);
  localparam logic [7:0] CNT_W_B   = 8'(CNT_W);

  // Edge registers: previous-cycle flag values. Resetting them to zero makes
  // flags already high at reset release count as events.
  logic [NUM_SRC-1:0] min_q, maj_q, scrub_q;
  logic [NUM_SRC-1:0] min_ev, maj_ev, scrub_ev;
  logic [31:0]        min_ev32, maj_ev32, scrub_ev32;

  logic [CNT_W-1:0]   min_cnt, maj_cnt, scrub_cnt;
  logic [NUM_SRC-1:0] min_sticky_q, maj_sticky_q;
  logic [31:0]        cyc_q;

  fe_state_e          state_q, state_d;
  logic               capture;
  err_type_e          fe_type_q;
  logic [4:0]         fe_src_q;
  logic [31:0]        fe_ts_q;
  logic               irq_q;

  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rd_mux;
  logic [31:0]        min_cnt32, maj_cnt32, scrub_cnt32;
  logic [31:0]        min_sticky32, maj_sticky32;

  assign min_ev   = min_err_i & ~min_q;
  assign maj_ev   = maj_err_i & ~maj_q;
  assign scrub_ev = scrub_i   & ~scrub_q;

  always_comb begin
    min_ev32   = '0;
    maj_ev32   = '0;
    scrub_ev32 = '0;
    min_ev32[NUM_SRC-1:0]   = min_ev;
    maj_ev32[NUM_SRC-1:0]   = maj_ev;
    scrub_ev32[NUM_SRC-1:0] = scrub_ev;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q   <= '0;
      maj_q   <= '0;
      scrub_q <= '0;
      cyc_q   <= '0;
    end else begin
      min_q   <= min_err_i;
      maj_q   <= maj_err_i;
      scrub_q <= scrub_i;
      cyc_q   <= cyc_q + 32'd1;
    end
  end

  fatori_mon_sat_ctr #(.W(CNT_W), .IW(POP_W)) u_min_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (popcount32(min_ev32)),
    .cnt_o  (min_cnt)
  );

  fatori_mon_sat_ctr #(.W(CNT_W), .IW(POP_W)) u_maj_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (popcount32(maj_ev32)),
    .cnt_o  (maj_cnt)
  );

  fatori_mon_sat_ctr #(.W(CNT_W), .IW(POP_W)) u_scrub_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (popcount32(scrub_ev32)),
    .cnt_o  (scrub_cnt)
  );

  // Clear wins first, then same-cycle events are OR-ed back in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_sticky_q <= '0;
      maj_sticky_q <= '0;
    end else begin
      min_sticky_q <= (clr_i ? '0 : min_sticky_q) | min_ev;
      maj_sticky_q <= (clr_i ? '0 : maj_sticky_q) | maj_ev;
    end
  end

  // First-error FSM. A clear is treated as forcing IDLE before looking at this
  // cycle's events, so a clear coinciding with an error re-arms and captures.
  always_comb begin
    state_d = clr_i ? ST_IDLE : state_q;
    capture = 1'b0;
    if (state_d == ST_IDLE && ((|min_ev) || (|maj_ev))) begin
      state_d = ST_CAPTURED;
      capture = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fe_type_q <= ERR_NONE;
      fe_src_q  <= '0;
      fe_ts_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= capture;
      if (capture) begin
        // A no-majority error outranks a minority one seen in the same cycle.
        fe_type_q <= (|maj_ev) ? ERR_MAJ : ERR_MIN;
        fe_src_q  <= (|maj_ev) ? lowest_idx32(maj_ev32) : lowest_idx32(min_ev32);
        fe_ts_q   <= cyc_q;
      end else if (clr_i) begin
        fe_type_q <= ERR_NONE;
        fe_src_q  <= '0;
        fe_ts_q   <= '0;
      end
    end
  end

  always_comb begin
    min_cnt32    = '0;
    maj_cnt32    = '0;
    scrub_cnt32  = '0;
    min_sticky32 = '0;
    maj_sticky32 = '0;
    min_cnt32[CNT_W-1:0]      = min_cnt;
    maj_cnt32[CNT_W-1:0]      = maj_cnt;
    scrub_cnt32[CNT_W-1:0]    = scrub_cnt;
    min_sticky32[NUM_SRC-1:0] = min_sticky_q;
    maj_sticky32[NUM_SRC-1:0] = maj_sticky_q;
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      REG_MIN_CNT:    rd_mux = min_cnt32;
      REG_MAJ_CNT:    rd_mux = maj_cnt32;
      REG_SCRUB_CNT:  rd_mux = scrub_cnt32;
      REG_MIN_STICKY: rd_mux = min_sticky32;
      REG_MAJ_STICKY: rd_mux = maj_sticky32;
      REG_FE_INFO:    rd_mux = {(state_q == ST_CAPTURED), fe_type_q, 24'd0, fe_src_q};
      REG_FE_TS:      rd_mux = fe_ts_q;
      REG_ID:         rd_mux = {NUM_SRC_B, CNT_W_B, ID_MAGIC};
      default:        rd_mux = '0;
    endcase
  end

  // Data is captured in the request cycle, so reads see pre-update state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= req_i ? rd_mux : 32'd0;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign irq_o       = irq_q;
  assign maj_alert_o = |maj_sticky_q;

endmodule

// File: tb/tb_fatori_mon_err_collector.sv
// tb/tb_fatori_mon_err_collector.sv - directed self-checking bench for the error collector
module tb_fatori_mon_err_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  min_err, maj_err, scrub;
  logic        clr, req;
  logic [2:0]  addr;
  logic        rvalid, maj_alert, irq;
  logic [31:0] rdata;

  logic [7:0]  min8, maj8, scrub8;
  logic        clr8, req8;
  logic [2:0]  addr8;
  logic        rvalid8, maj_alert8, irq8;
  logic [31:0] rdata8;

  int          checks   = 0;
  int          failures = 0;
  int          irq_cnt  = 0;
  logic [31:0] tb_cyc;
  logic [31:0] exp_ts;
  logic [31:0] d;
  logic [31:0] sweep_exp [8];

  always #5 clk = ~clk;

  fatori_mon_err_collector #(.NUM_SRC(8), .CNT_W(16)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .min_err_i   (min_err),
    .maj_err_i   (maj_err),
    .scrub_i     (scrub),
    .clr_i       (clr),
    .req_i       (req),
    .addr_i      (addr),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .maj_alert_o (maj_alert),
    .irq_o       (irq)
  );

  fatori_mon_err_collector #(.NUM_SRC(8), .CNT_W(8)) u_dut8 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .min_err_i   (min8),
    .maj_err_i   (maj8),
    .scrub_i     (scrub8),
    .clr_i       (clr8),
    .req_i       (req8),
    .addr_i      (addr8),
    .rvalid_o    (rvalid8),
    .rdata_o     (rdata8),
    .maj_alert_o (maj_alert8),
    .irq_o       (irq8)
  );

  // Cycles elapsed since reset release: the timestamp the DUT should record
  // for an event driven in the current cycle.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  always @(negedge clk) begin
    if (irq === 1'b1) irq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input bit sel8, input logic [2:0] a, output logic [31:0] data);
    @(negedge clk);
    if (sel8) begin req8 = 1'b1; addr8 = a; end
    else      begin req  = 1'b1; addr  = a; end
    @(negedge clk);
    req  = 1'b0;
    req8 = 1'b0;
    if (sel8) begin
      check("rvalid8", {31'd0, rvalid8}, 32'd1);
      data = rdata8;
    end else begin
      check("rvalid", {31'd0, rvalid}, 32'd1);
      data = rdata;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    min_err = '0; maj_err = '0; scrub = '0; clr = 1'b0; req = 1'b1; addr = 3'd7;
    min8 = '0; maj8 = '0; scrub8 = '0; clr8 = 1'b0; req8 = 1'b0; addr8 = 3'd0;

    // Reset state, with a read request pending through reset.
    repeat (3) @(negedge clk);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_alert", {31'd0, maj_alert}, 32'd0);
    req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rvalid", {31'd0, rvalid}, 32'd0);

    // Single no-majority pulse on source 3 at cycle 100.
    while (tb_cyc != 32'd100) @(negedge clk);
    maj_err = 8'h08;
    @(negedge clk);
    maj_err = 8'h00;
    repeat (3) @(negedge clk);
    rd(0, 3'd1, d); check("maj_cnt_1", d, 32'd1);
    rd(0, 3'd4, d); check("maj_sticky_8", d, 32'h8);
    rd(0, 3'd5, d); check("fe_info_maj3", d, 32'hC000_0003);
    rd(0, 3'd6, d); check("fe_ts_100", d, 32'd100);
    rd(0, 3'd0, d); check("min_cnt_0", d, 32'd0);
    check("irq_once", irq_cnt, 32'd1);
    check("alert_set", {31'd0, maj_alert}, 32'd1);

    // Clear alone.
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    rd(0, 3'd4, d); check("clr_maj_sticky", d, 32'd0);
    rd(0, 3'd5, d); check("clr_fe_info", d, 32'd0);
    rd(0, 3'd6, d); check("clr_fe_ts", d, 32'd0);
    check("clr_alert", {31'd0, maj_alert}, 32'd0);

    // Two minority errors in one cycle, then a later no-majority error.
    @(negedge clk); min_err = 8'h24;
    @(negedge clk); min_err = 8'h00;
    repeat (2) @(negedge clk);
    rd(0, 3'd0, d); check("min_cnt_2", d, 32'd2);
    rd(0, 3'd3, d); check("min_sticky_24", d, 32'h24);
    rd(0, 3'd5, d); check("fe_info_min2", d, 32'hA000_0002);
    check("irq_second", irq_cnt, 32'd2);
    @(negedge clk); maj_err = 8'h01;
    @(negedge clk); maj_err = 8'h00;
    repeat (2) @(negedge clk);
    rd(0, 3'd5, d); check("fe_info_kept", d, 32'hA000_0002);
    rd(0, 3'd1, d); check("maj_cnt_after_clr", d, 32'd1);
    check("irq_no_rearm", irq_cnt, 32'd2);
    check("alert_src0", {31'd0, maj_alert}, 32'd1);

    // Level held for 50 cycles counts once.
    @(negedge clk); min_err = 8'h02;
    repeat (50) @(negedge clk);
    min_err = 8'h00;
    rd(0, 3'd0, d); check("min_held_once", d, 32'd3);

    // Clear coinciding with a no-majority rise on source 7.
    @(negedge clk); clr = 1'b1; maj_err = 8'h80; exp_ts = tb_cyc;
    @(negedge clk); clr = 1'b0; maj_err = 8'h00;
    rd(0, 3'd1, d); check("clr_ev_maj_cnt", d, 32'd1);
    rd(0, 3'd4, d); check("clr_ev_sticky", d, 32'h80);
    rd(0, 3'd5, d); check("clr_ev_fe_info", d, 32'hC000_0007);
    check("clr_ev_irq", irq_cnt, 32'd3);

    // Back-to-back sweep of all registers.
    sweep_exp[0] = 32'd0;
    sweep_exp[1] = 32'd1;
    sweep_exp[2] = 32'd0;
    sweep_exp[3] = 32'd0;
    sweep_exp[4] = 32'h80;
    sweep_exp[5] = 32'hC000_0007;
    sweep_exp[6] = exp_ts;
    sweep_exp[7] = 32'h0810_FA70;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("sweep_rvalid%0d", i - 1), {31'd0, rvalid}, 32'd1);
        check($sformatf("sweep_rdata%0d", i - 1), rdata, sweep_exp[i-1]);
      end
      if (i < 8) begin req = 1'b1; addr = 3'(i); end
      else       req = 1'b0;
    end
    @(negedge clk);
    check("sweep_idle_rvalid", {31'd0, rvalid}, 32'd0);
    check("sweep_idle_rdata", rdata, 32'd0);

    // 8-bit counter saturation on the second instance.
    for (int p = 0; p < 250; p++) begin
      @(negedge clk); scrub8 = 8'h01;
      @(negedge clk); scrub8 = 8'h00;
    end
    rd(1, 3'd2, d); check("scrub8_250", d, 32'd250);
    for (int p = 0; p < 50; p++) begin
      @(negedge clk); scrub8 = 8'h01;
      @(negedge clk); scrub8 = 8'h00;
    end
    rd(1, 3'd2, d); check("scrub8_sat", d, 32'hFF);
    rd(1, 3'd7, d); check("id8", d, 32'h0808_FA70);
    rd(1, 3'd5, d); check("scrub8_no_fe", d, 32'd0);
    check("scrub8_no_irq", {31'd0, irq8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", tb_cyc, 32'd0);
    $fatal(1, "timeout");
  end

endmodule
